riscv_core_dcache_writeback_buffer: RTL and testbench

Victim write-back buffer between the dcache controller and the AXI write channels. On a dirty eviction it accepts the victim block and its line address, queues the pair in a small FIFO, and drains it to memory as an AXI4 INCR burst on AW/W/B. A lookup port lets the refill path detect a pending write-back to the same line, so a refill never reads stale memory.

---
 rtl/riscv_core_dcache_writeback_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_riscv_core_dcache_writeback_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_dcache_writeback_buffer.sv
// Victim write-back buffer: queues dirty evictions and drains each one as an AXI4 INCR burst.
// Build option DCACHE_WB_FORWARD_EN returns the youngest matching entry's data on the lookup port.
module riscv_core_dcache_writeback_buffer #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned BLOCK_WIDTH    = 256,
    parameter int unsigned AXI_DATA_WIDTH = 256,
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned LINE_OFFSET    = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wb_valid,
    output logic                        o_wb_ready,
    input  logic [ADDR_WIDTH-1:0]       i_wb_addr,
    input  logic [BLOCK_WIDTH-1:0]      i_wb_block,
    input  logic [ADDR_WIDTH-1:0]       i_lookup_addr,
    output logic                        o_lookup_hit,
    output logic [BLOCK_WIDTH-1:0]      o_lookup_block,
    output logic                        o_empty,
    output logic                        o_wb_error,
    output logic                        o_awvalid,
    input  logic                        i_awready,
    output logic [ADDR_WIDTH-1:0]       o_awaddr,
    output logic [7:0]                  o_awlen,
    output logic [2:0]                  o_awsize,
    output logic [1:0]                  o_awburst,
    output logic                        o_wvalid,
    input  logic                        i_wready,
    output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
    output logic                        o_wlast,
    input  logic                        i_bvalid,
    output logic                        o_bready,
    input  logic [1:0]                  i_bresp
);

    localparam int unsigned BEATS  = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SIZE   = $clog2(AXI_DATA_WIDTH / 8);

    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH-LINE_OFFSET){1'b1}}, {LINE_OFFSET{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RESP
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic [DEPTH-1:0]       entry_valid;
    logic [ADDR_WIDTH-1:0]  entry_addr  [DEPTH];
    logic [BLOCK_WIDTH-1:0] entry_block [DEPTH];
    logic [BLOCK_WIDTH-1:0] head_block;
    logic [BEAT_W-1:0]      beat;
    logic                   aw_done;
    logic                   w_done;
    logic                   push;
    logic                   pop;
    logic                   aw_hs;
    logic                   w_hs;
    logic [PTR_W-1:0]       idx;
    logic                   unused_lookup_bits;

    assign o_wb_ready = (count < FULL_CNT);
    assign push       = i_wb_valid & o_wb_ready;
    assign pop        = o_bready & i_bvalid;
    assign aw_hs      = o_awvalid & i_awready;
    assign w_hs       = o_wvalid & i_wready;
    assign o_empty    = (count == '0) && (state == IDLE);

    assign o_awaddr   = entry_addr[rd_ptr];
    assign o_awlen    = 8'(BEATS - 1);
    assign o_awsize   = 3'(SIZE);
    assign o_awburst  = 2'b01;
    assign o_wstrb    = '1;
    assign head_block = entry_block[rd_ptr];

    assign unused_lookup_bits = ^i_lookup_addr[LINE_OFFSET-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (push) begin
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            entry_addr[wr_ptr]  <= i_wb_addr & LINE_MASK;
            entry_block[wr_ptr] <= i_wb_block;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            o_awvalid  <= 1'b0;
            o_wvalid   <= 1'b0;
            o_wlast    <= 1'b0;
            o_bready   <= 1'b0;
            o_wb_error <= 1'b0;
            beat       <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            o_wb_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state     <= SEND;
                        o_awvalid <= 1'b1;
                        o_wvalid  <= 1'b1;
                        o_wlast   <= (BEATS == 1);
                        beat      <= '0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                    end
                end
                SEND: begin
                    if (aw_hs) begin
                        o_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        if (o_wlast) begin
                            o_wvalid <= 1'b0;
                            o_wlast  <= 1'b0;
                            w_done   <= 1'b1;
                        end else begin
                            beat    <= beat + 1'b1;
                            o_wlast <= ((beat + 1'b1) == LAST_BEAT);
                        end
                    end
                    // AW and W finish in either order; leave once both have completed
                    if ((aw_done || aw_hs) && (w_done || (w_hs && o_wlast))) begin
                        state    <= RESP;
                        o_bready <= 1'b1;
                    end
                end
                RESP: begin
                    if (i_bvalid) begin
                        state      <= IDLE;
                        o_bready   <= 1'b0;
                        o_wb_error <= (i_bresp != 2'b00);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_wdata = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat == BEAT_W'(k)) begin
                o_wdata = head_block[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end
    end

    // Scan oldest to youngest so the last match wins as the youngest copy
    always_comb begin
        o_lookup_hit   = 1'b0;
        o_lookup_block = '0;
        idx            = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (entry_valid[idx] &&
                (entry_addr[idx][ADDR_WIDTH-1:LINE_OFFSET] ==
                 i_lookup_addr[ADDR_WIDTH-1:LINE_OFFSET])) begin
                o_lookup_hit = 1'b1;
`ifdef DCACHE_WB_FORWARD_EN
                o_lookup_block = entry_block[idx];
`else
                o_lookup_block = '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_dcache_writeback_buffer.sv
// Directed bench for the dcache write-back buffer: 256-bit single-beat instance plus a 64-bit four-beat instance.
module tb_riscv_core_dcache_writeback_buffer;

    logic         clk;
    logic         rst;
    int           checks;
    int           errors;

    logic         wb_valid, wb_ready;
    logic [63:0]  wb_addr;
    logic [255:0] wb_block;
    logic [63:0]  lookup_addr;
    logic         lookup_hit;
    logic [255:0] lookup_block;
    logic         empty, wb_error;
    logic         awvalid, awready;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         wvalid, wready, wlast;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         bvalid, bready;
    logic [1:0]   bresp;

    logic         m_wb_valid, m_wb_ready;
    logic [63:0]  m_wb_addr;
    logic [255:0] m_wb_block;
    logic [63:0]  m_lookup_addr;
    logic         m_lookup_hit;
    logic [255:0] m_lookup_block;
    logic         m_empty, m_wb_error;
    logic         m_awvalid, m_awready;
    logic [63:0]  m_awaddr;
    logic [7:0]   m_awlen;
    logic [2:0]   m_awsize;
    logic [1:0]   m_awburst;
    logic         m_wvalid, m_wready, m_wlast;
    logic [63:0]  m_wdata;
    logic [7:0]   m_wstrb;
    logic         m_bvalid, m_bready;
    logic [1:0]   m_bresp;

    riscv_core_dcache_writeback_buffer dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_valid(wb_valid), .o_wb_ready(wb_ready), .i_wb_addr(wb_addr), .i_wb_block(wb_block),
        .i_lookup_addr(lookup_addr), .o_lookup_hit(lookup_hit), .o_lookup_block(lookup_block),
        .o_empty(empty), .o_wb_error(wb_error),
        .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr), .o_awlen(awlen),
        .o_awsize(awsize), .o_awburst(awburst),
        .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast),
        .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp)
    );

    riscv_core_dcache_writeback_buffer #(.AXI_DATA_WIDTH(64)) dut64 (
        .i_clk(clk), .i_rst(rst),
        .i_wb_valid(m_wb_valid), .o_wb_ready(m_wb_ready), .i_wb_addr(m_wb_addr), .i_wb_block(m_wb_block),
        .i_lookup_addr(m_lookup_addr), .o_lookup_hit(m_lookup_hit), .o_lookup_block(m_lookup_block),
        .o_empty(m_empty), .o_wb_error(m_wb_error),
        .o_awvalid(m_awvalid), .i_awready(m_awready), .o_awaddr(m_awaddr), .o_awlen(m_awlen),
        .o_awsize(m_awsize), .o_awburst(m_awburst),
        .o_wvalid(m_wvalid), .i_wready(m_wready), .o_wdata(m_wdata), .o_wstrb(m_wstrb), .o_wlast(m_wlast),
        .i_bvalid(m_bvalid), .o_bready(m_bready), .i_bresp(m_bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid got=%b want=0", awvalid); end
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got=%b want=0", wvalid); end
        checks++; if (bready !== 1'b0) begin errors++; $display("FAIL reset_bready got=%b want=0", bready); end
        checks++; if (wlast !== 1'b0) begin errors++; $display("FAIL reset_wlast got=%b want=0", wlast); end
        checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL reset_wb_error got=%b want=0", wb_error); end
        checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL reset_lookup_hit got=%b want=0", lookup_hit); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", empty); end
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_wb_ready got=%b want=1", wb_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [255:0] blk;
        blk = {64'h2020_1F1E_1D1C_1B1A, 64'h1918_1716_1514_1312, 64'h1110_0F0E_0D0C_0B0A, 64'h0908_0706_0403_0201};
        wb_addr = 64'h8000_1234; wb_block = blk; wb_valid = 1'b1; awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        wb_valid = 1'b0;
        checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL single_awvalid_edge1 got=%b want=0", awvalid); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_queued got=%b want=0", empty); end
        @(negedge clk);
        checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL single_awvalid_edge2 got=%b want=1", awvalid); end
        checks++; if (awaddr !== 64'h8000_1220) begin errors++; $display("FAIL single_awaddr got=%h want=8000_1220", awaddr); end
        checks++; if (awlen !== 8'd0) begin errors++; $display("FAIL single_awlen got=%0d want=0", awlen); end
        checks++; if (awsize !== 3'd5) begin errors++; $display("FAIL single_awsize got=%0d want=5", awsize); end
        checks++; if (awburst !== 2'b01) begin errors++; $display("FAIL single_awburst got=%b want=01", awburst); end
        checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL single_wvalid got=%b want=1", wvalid); end
        checks++; if (wlast !== 1'b1) begin errors++; $display("FAIL single_wlast got=%b want=1", wlast); end
        checks++; if (wdata !== blk) begin errors++; $display("FAIL single_wdata got=%h want=%h", wdata, blk); end
        checks++; if (wstrb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL single_wstrb got=%h want=ffffffff", wstrb); end
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL single_valids_drop got=%b%b want=00", awvalid, wvalid); end
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL single_bready got=%b want=1", bready); end
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_done got=%b want=1", empty); end
        checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL single_wb_error got=%b want=0", wb_error); end
        checks++; if (bready !== 1'b0) begin errors++; $display("FAIL single_bready_drop got=%b want=0", bready); end
    endtask

    task automatic test_full_backpressure;
        logic [255:0] blk_a, blk_b;
        blk_a = {4{64'hAAAA_0000_AAAA_0001}};
        blk_b = {4{64'hBBBB_0000_BBBB_0002}};
        wb_addr = 64'h1000_0000; wb_block = blk_a; wb_valid = 1'b1;
        @(negedge clk);
        wb_addr = 64'h2000_0048; wb_block = blk_b;
        @(negedge clk);
        wb_valid = 1'b0;
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL full_wb_ready got=%b want=0", wb_ready); end
        checks++; if (awaddr !== 64'h1000_0000) begin errors++; $display("FAIL full_first_awaddr got=%h want=1000_0000", awaddr); end
        repeat (2) @(negedge clk);
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL full_wb_ready_held got=%b want=0", wb_ready); end
        checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL full_awvalid_stable got=%b want=1", awvalid); end
        checks++; if (wdata !== blk_a) begin errors++; $display("FAIL full_wdata_stable got=%h want=%h", wdata, blk_a); end
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_b got=%b want=1", wb_ready); end
        @(negedge clk);
        checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL full_second_awvalid got=%b want=1", awvalid); end
        checks++; if (awaddr !== 64'h2000_0040) begin errors++; $display("FAIL full_second_awaddr got=%h want=2000_0040", awaddr); end
        checks++; if (wdata !== blk_b) begin errors++; $display("FAIL full_second_wdata got=%h want=%h", wdata, blk_b); end
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty_done got=%b want=1", empty); end
    endtask

    task automatic test_multibeat;
        logic [63:0] w0, w1, w2, w3;
        w0 = 64'h0000_0000_0000_00A0; w1 = 64'h1111_1111_1111_11B1;
        w2 = 64'h2222_2222_2222_22C2; w3 = 64'h3333_3333_3333_33D3;
        m_wb_addr = 64'h0000_0900; m_wb_block = {w3, w2, w1, w0}; m_wb_valid = 1'b1;
        @(negedge clk);
        m_wb_valid = 1'b0;
        @(negedge clk);
        checks++; if (m_awlen !== 8'd3) begin errors++; $display("FAIL multi_awlen got=%0d want=3", m_awlen); end
        checks++; if (m_awsize !== 3'd3) begin errors++; $display("FAIL multi_awsize got=%0d want=3", m_awsize); end
        checks++; if (m_wdata !== w0 || m_wlast !== 1'b0) begin errors++; $display("FAIL multi_beat0 got=%h/%b want=%h/0", m_wdata, m_wlast, w0); end
        checks++; if (m_wstrb !== 8'hFF) begin errors++; $display("FAIL multi_wstrb got=%h want=ff", m_wstrb); end
        m_awready = 1'b1; m_wready = 1'b1;
        @(negedge clk);
        m_awready = 1'b0; m_wready = 1'b0;
        checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL multi_awvalid_drop got=%b want=0", m_awvalid); end
        checks++; if (m_wdata !== w1 || m_wlast !== 1'b0) begin errors++; $display("FAIL multi_beat1 got=%h/%b want=%h/0", m_wdata, m_wlast, w1); end
        @(negedge clk);
        checks++; if (m_wdata !== w1 || m_wvalid !== 1'b1) begin errors++; $display("FAIL multi_beat1_hold got=%h/%b want=%h/1", m_wdata, m_wvalid, w1); end
        m_wready = 1'b1;
        @(negedge clk);
        checks++; if (m_wdata !== w2 || m_wlast !== 1'b0) begin errors++; $display("FAIL multi_beat2 got=%h/%b want=%h/0", m_wdata, m_wlast, w2); end
        @(negedge clk);
        checks++; if (m_wdata !== w3 || m_wlast !== 1'b1) begin errors++; $display("FAIL multi_beat3 got=%h/%b want=%h/1", m_wdata, m_wlast, w3); end
        @(negedge clk);
        m_wready = 1'b0;
        checks++; if (m_wvalid !== 1'b0 || m_bready !== 1'b1) begin errors++; $display("FAIL multi_resp got=%b/%b want=0/1", m_wvalid, m_bready); end
        m_bvalid = 1'b1; m_bresp = 2'b00;
        @(negedge clk);
        m_bvalid = 1'b0;
        checks++; if (m_empty !== 1'b1) begin errors++; $display("FAIL multi_empty got=%b want=1", m_empty); end
    endtask

    task automatic test_lookup;
        logic [255:0] blk;
        blk = {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000};
        wb_addr = 64'h4000_0040; wb_block = blk; wb_valid = 1'b1;
        @(negedge clk);
        wb_valid = 1'b0;
        lookup_addr = 64'h4000_005C; #1;
        checks++; if (lookup_hit !== 1'b1) begin errors++; $display("FAIL lookup_hit_queued got=%b want=1", lookup_hit); end
`ifdef DCACHE_WB_FORWARD_EN
        checks++; if (lookup_block !== blk) begin errors++; $display("FAIL lookup_fwd_block got=%h want=%h", lookup_block, blk); end
`else
        checks++; if (lookup_block !== 256'd0) begin errors++; $display("FAIL lookup_block_tied got=%h want=0", lookup_block); end
`endif
        lookup_addr = 64'h4000_0060; #1;
        checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL lookup_next_line got=%b want=0", lookup_hit); end
        lookup_addr = 64'h4000_005C;
        @(negedge clk);
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00; #1;
        checks++; if (lookup_hit !== 1'b1) begin errors++; $display("FAIL lookup_hit_inflight got=%b want=1", lookup_hit); end
        @(negedge clk);
        bvalid = 1'b0; #1;
        checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL lookup_hit_retired got=%b want=0", lookup_hit); end
    endtask

    task automatic test_bresp_error;
        wb_addr = 64'h5000_0000; wb_block = {4{64'h5555_5555_5555_5555}}; wb_valid = 1'b1;
        @(negedge clk);
        wb_valid = 1'b0;
        @(negedge clk);
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
        checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL err_before got=%b want=0", wb_error); end
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        checks++; if (wb_error !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b want=1", wb_error); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL err_retired got=%b want=1", empty); end
        @(negedge clk);
        checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b want=0", wb_error); end
    endtask

    task automatic test_reset_midburst;
        wb_addr = 64'h6000_0000; wb_block = {4{64'h6666_6666_6666_6666}}; wb_valid = 1'b1;
        @(negedge clk);
        wb_valid = 1'b0;
        @(negedge clk);
        checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL rstmid_send got=%b want=1", awvalid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) begin errors++; $display("FAIL rstmid_drop got=%b%b%b want=000", awvalid, wvalid, bready); end
        checks++; if (wb_ready !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_cleared got=%b%b want=11", wb_ready, empty); end
        checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b want=0", wb_error); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (awvalid !== 1'b0 || wb_error !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_after got=%b%b%b want=001", awvalid, wb_error, empty); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        wb_valid = 1'b0; wb_addr = '0; wb_block = '0; lookup_addr = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        m_wb_valid = 1'b0; m_wb_addr = '0; m_wb_block = '0; m_lookup_addr = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        test_reset;
        test_single;
        test_full_backpressure;
        test_multibeat;
        test_lookup;
        test_bresp_error;
        test_reset_midburst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
